// File: rtl/gpr_pkg.sv
// Shared constants and types for the multi-context GPR file and its scoreboard.
package gpr_pkg;

  localparam int WORD_DATA_W = 32;
  localparam int REG_ADDR_W  = 5;
  localparam int REG_NUM     = 32;

  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  // Default-geometry register index: thread id above register address.
  typedef struct packed {
    logic [1:0]            tid;
    logic [REG_ADDR_W-1:0] addr;
  } reg_idx_t;

endpackage

// File: rtl/gpr_scoreboard.sv
// Pending-bit scoreboard with population counter; busy lookups are combinational, count is registered.
// No backpressure. GPR_BYPASS_EN masks busy for a same-cycle write to the looked-up register.
module gpr_scoreboard
  import gpr_pkg::*;
#(
  parameter int ADDR_W     = REG_ADDR_W,
  parameter int NUM_THREAD = 4,
  parameter int NUM_RD     = 2,
  localparam int THREAD_W  = (NUM_THREAD > 1) ? $clog2(NUM_THREAD) : 1,
  localparam int IDX_W     = THREAD_W + ADDR_W,
  localparam int CNT_W     = THREAD_W + ADDR_W + 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       we_,
  input  logic [THREAD_W-1:0]        wr_tid,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic                       set_en_,
  input  logic [THREAD_W-1:0]        set_tid,
  input  logic [ADDR_W-1:0]          set_addr,
  input  logic [NUM_RD*THREAD_W-1:0] rd_tid,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD-1:0]          rd_busy,
  output logic [CNT_W-1:0]           pend_cnt
);

  localparam int NREG = 2 ** IDX_W;

  logic [NREG-1:0]  pend;
  logic [NREG-1:0]  pend_nxt;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] set_idx;
  logic             clr_hit;
  logic             set_hit;
  logic             inc;
  logic             dec;

  assign wr_idx  = {wr_tid, wr_addr};
  assign set_idx = {set_tid, set_addr};
  assign clr_hit = (we_ == ENABLE_) && (wr_addr != '0);
  assign set_hit = (set_en_ == ENABLE_) && (set_addr != '0);

  // A mark lands after the clear so a new producer wins on the same register.
  always_comb begin
    pend_nxt = pend;
    if (clr_hit) pend_nxt[wr_idx] = 1'b0;
    if (set_hit) pend_nxt[set_idx] = 1'b1;
  end

  assign inc = set_hit && !pend[set_idx];
  assign dec = clr_hit && pend[wr_idx] && !(set_hit && (set_idx == wr_idx));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend     <= '0;
      pend_cnt <= '0;
    end else begin
      pend     <= pend_nxt;
      pend_cnt <= pend_cnt + CNT_W'(inc) - CNT_W'(dec);
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_busy
    logic [THREAD_W-1:0] tid;
    logic [ADDR_W-1:0]   addr;
    logic                byp;
    assign tid  = rd_tid[k*THREAD_W +: THREAD_W];
    assign addr = rd_addr[k*ADDR_W +: ADDR_W];
`ifdef GPR_BYPASS_EN
    assign byp = reset && (we_ == ENABLE_) && (wr_tid == tid) && (wr_addr == addr) && (addr != '0);
`else
    assign byp = 1'b0;
`endif
    assign rd_busy[k] = pend[{tid, addr}] && !byp;
  end

endmodule

// File: rtl/gpr_mt.sv
// Multi-context GPR file: NUM_RD combinational read ports, one write port, pending scoreboard.
// No backpressure; writes/marks take effect on the edge. GPR_BYPASS_EN forwards same-cycle writes to reads.
module gpr_mt
  import gpr_pkg::*;
#(
  parameter int DATA_W     = WORD_DATA_W,
  parameter int ADDR_W     = REG_ADDR_W,
  parameter int NUM_THREAD = 4,
  parameter int NUM_RD     = 2,
  localparam int THREAD_W  = (NUM_THREAD > 1) ? $clog2(NUM_THREAD) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_RD*THREAD_W-1:0]   rd_tid,
  input  logic [NUM_RD*ADDR_W-1:0]     rd_addr,
  output logic [NUM_RD*DATA_W-1:0]     rd_data,
  output logic [NUM_RD-1:0]            rd_busy,
  input  logic                         we_,
  input  logic [THREAD_W-1:0]          wr_tid,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [DATA_W-1:0]            wr_data,
  input  logic                         set_en_,
  input  logic [THREAD_W-1:0]          set_tid,
  input  logic [ADDR_W-1:0]            set_addr,
  output logic [THREAD_W+ADDR_W:0]     pend_cnt
);

  localparam int IDX_W = THREAD_W + ADDR_W;
  localparam int NREG  = 2 ** IDX_W;

  logic [DATA_W-1:0] regs [NREG];
  logic              wr_hit;

  assign wr_hit = (we_ == ENABLE_) && (wr_addr != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_hit) begin
      regs[{wr_tid, wr_addr}] <= wr_data;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [THREAD_W-1:0] tid;
    logic [ADDR_W-1:0]   addr;
    logic                byp;
    assign tid  = rd_tid[k*THREAD_W +: THREAD_W];
    assign addr = rd_addr[k*ADDR_W +: ADDR_W];
`ifdef GPR_BYPASS_EN
    assign byp = reset && wr_hit && (wr_tid == tid) && (wr_addr == addr);
`else
    assign byp = 1'b0;
`endif
    assign rd_data[k*DATA_W +: DATA_W] = (addr == '0) ? '0 :
                                         byp          ? wr_data :
                                                        regs[{tid, addr}];
  end

  gpr_scoreboard #(
    .ADDR_W     (ADDR_W),
    .NUM_THREAD (NUM_THREAD),
    .NUM_RD     (NUM_RD)
  ) u_sb (
    .clk      (clk),
    .reset    (reset),
    .we_      (we_),
    .wr_tid   (wr_tid),
    .wr_addr  (wr_addr),
    .set_en_  (set_en_),
    .set_tid  (set_tid),
    .set_addr (set_addr),
    .rd_tid   (rd_tid),
    .rd_addr  (rd_addr),
    .rd_busy  (rd_busy),
    .pend_cnt (pend_cnt)
  );

endmodule

// File: tb/tb_gpr_mt.sv
// Randomized + directed bench for gpr_mt with a queue scoreboard against an array reference model.
module tb_gpr_mt;

  localparam int NT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  rd_tid;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        we_;
  logic [1:0]  wr_tid;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        set_en_;
  logic [1:0]  set_tid;
  logic [4:0]  set_addr;
  logic [7:0]  pend_cnt;

  gpr_mt dut (
    .clk(clk), .reset(reset), .rd_tid(rd_tid), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .we_(we_), .wr_tid(wr_tid), .wr_addr(wr_addr), .wr_data(wr_data),
    .set_en_(set_en_), .set_tid(set_tid), .set_addr(set_addr), .pend_cnt(pend_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d1;
    logic [31:0] d0;
    logic [1:0]  b;
    logic [7:0]  cnt;
  } exp_t;

  exp_t        q[$];
  logic        chk_vld = 1'b0;
  int          n_total = 0;
  int          n_pass  = 0;

  logic [31:0] mem  [NT][32];
  bit          pend [NT][32];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) $display("FAIL %s got %h want %h at %0t", nm, got, want, $time);
    else n_pass++;
  endtask

  always @(negedge clk) begin
    if (chk_vld) begin
      if (q.size() == 0) begin
        n_total++;
        $display("FAIL queue_underflow got empty want entry at %0t", $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("rd_data0", rd_data[31:0], e.d0);
        chk("rd_data1", rd_data[63:32], e.d1);
        chk("rd_busy", {30'd0, rd_busy}, {30'd0, e.b});
        chk("pend_cnt", {24'd0, pend_cnt}, {24'd0, e.cnt});
      end
    end
  end

  always @(negedge clk) begin
    assert (int'(rd_tid[1:0]) < NT && int'(rd_tid[3:2]) < NT && int'(wr_tid) < NT && int'(set_tid) < NT)
      else $error("thread id out of range");
  end

  function automatic int model_cnt();
    int c = 0;
    for (int t = 0; t < NT; t++)
      for (int a = 0; a < 32; a++) c += int'(pend[t][a]);
    return c;
  endfunction

  function automatic void model_clear();
    for (int t = 0; t < NT; t++)
      for (int a = 0; a < 32; a++) begin
        mem[t][a]  = '0;
        pend[t][a] = 1'b0;
      end
  endfunction

  // Expected read of one port given pre-edge model state and this cycle's write.
  function automatic logic [32:0] model_rd(input logic [1:0] t, input logic [4:0] a);
    logic [31:0] d;
    logic        b;
    if (a == 0) return 33'd0;
    d = mem[t][a];
    b = pend[t][a];
`ifdef GPR_BYPASS_EN
    if (we_ == 1'b0 && wr_tid == t && wr_addr == a) begin
      d = wr_data;
      b = 1'b0;
    end
`endif
    return {b, d};
  endfunction

  task automatic step(input logic we, input logic [1:0] wt, input logic [4:0] wa, input logic [31:0] wd,
                      input logic se, input logic [1:0] st, input logic [4:0] sa,
                      input logic [1:0] t0, input logic [4:0] a0, input logic [1:0] t1, input logic [4:0] a1);
    exp_t        e;
    logic [32:0] r0, r1;
    we_ = we; wr_tid = wt; wr_addr = wa; wr_data = wd;
    set_en_ = se; set_tid = st; set_addr = sa;
    rd_tid = {t1, t0}; rd_addr = {a1, a0};
    r0 = model_rd(t0, a0);
    r1 = model_rd(t1, a1);
    e.d0 = r0[31:0]; e.d1 = r1[31:0];
    e.b = {r1[32], r0[32]};
    e.cnt = 8'(model_cnt());
    q.push_back(e);
    chk_vld = 1'b1;
    @(posedge clk);
    chk_vld = 1'b0;
    if (we == 1'b0 && wa != 0) begin
      mem[wt][wa]  = wd;
      pend[wt][wa] = 1'b0;
    end
    if (se == 1'b0 && sa != 0) pend[st][sa] = 1'b1;
    #1;
  endtask

  task automatic rd_step(input logic [1:0] t0, input logic [4:0] a0, input logic [1:0] t1, input logic [4:0] a1);
    step(1'b1, 2'd0, 5'd0, 32'd0, 1'b1, 2'd0, 5'd0, t0, a0, t1, a1);
  endtask

  task automatic rand_step();
    step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)), $urandom,
         1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)),
         2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)));
  endtask

  // Reset asserted mid-cycle while a write and a mark are presented; outputs must clear at once.
  task automatic reset_pulse();
    exp_t e;
    reset = 1'b0;
    we_ = 1'b0; wr_tid = 2'd1; wr_addr = 5'd5; wr_data = $urandom;
    set_en_ = 1'b0; set_tid = 2'd2; set_addr = 5'd3;
    rd_tid = {2'd2, 2'd1}; rd_addr = {5'd3, 5'd6};
    model_clear();
    e = '0;
    q.push_back(e);
    chk_vld = 1'b1;
    @(posedge clk);
    chk_vld = 1'b0;
    #2;
    reset = 1'b1;
    we_ = 1'b1; set_en_ = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    we_ = 1'b1; wr_tid = '0; wr_addr = '0; wr_data = '0;
    set_en_ = 1'b1; set_tid = '0; set_addr = '0;
    rd_tid = '0; rd_addr = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    reset_pulse();

    // Prior writes/marks, then a mid-cycle reset that must wipe them.
    for (int i = 0; i < 20; i++) rand_step();
    reset_pulse();
    rd_step(2'd1, 5'd5, 2'd2, 5'd3);

    // Context isolation.
    step(1'b0, 2'd1, 5'd5, 32'hDEADBEEF, 1'b1, 2'd0, 5'd0, 2'd1, 5'd5, 2'd2, 5'd5);
    rd_step(2'd1, 5'd5, 2'd2, 5'd5);

    // Register 0 ignores writes and marks.
    step(1'b0, 2'd0, 5'd0, 32'h1234, 1'b0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd1, 5'd5);
    rd_step(2'd0, 5'd0, 2'd0, 5'd0);

    // Scoreboard round-trip on tid3 r7.
    step(1'b1, 2'd0, 5'd0, 32'd0, 1'b0, 2'd3, 5'd7, 2'd3, 5'd7, 2'd2, 5'd7);
    rd_step(2'd3, 5'd7, 2'd2, 5'd7);
    step(1'b0, 2'd3, 5'd7, 32'h55, 1'b1, 2'd0, 5'd0, 2'd3, 5'd7, 2'd3, 5'd7);
    rd_step(2'd3, 5'd7, 2'd3, 5'd7);

    // Same-cycle write and mark on an already-pending register.
    step(1'b1, 2'd0, 5'd0, 32'd0, 1'b0, 2'd0, 5'd9, 2'd0, 5'd9, 2'd0, 5'd9);
    step(1'b0, 2'd0, 5'd9, 32'hA5A5_0009, 1'b0, 2'd0, 5'd9, 2'd0, 5'd9, 2'd1, 5'd9);
    rd_step(2'd0, 5'd9, 2'd1, 5'd9);

    // Fill every pending bit, then drain them all.
    for (int t = 0; t < NT; t++)
      for (int a = 1; a < 32; a++)
        step(1'b1, 2'd0, 5'd0, 32'd0, 1'b0, 2'(t), 5'(a), 2'(t), 5'(a), 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)));
    chk("fill_cnt", {24'd0, pend_cnt}, 32'd124);
    for (int t = 0; t < NT; t++)
      for (int a = 1; a < 32; a++)
        step(1'b0, 2'(t), 5'(a), $urandom, 1'b1, 2'd0, 5'd0, 2'(t), 5'(a), 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)));
    chk("drain_cnt", {24'd0, pend_cnt}, 32'd0);

    for (int i = 0; i < 300; i++) rand_step();

    repeat (2) @(negedge clk);
    n_total++;
    if (q.size() != 0) $display("FAIL queue_drain got %0d want 0", q.size());
    else n_pass++;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/gpr_mt.md
Name: gpr_mt

Overview:
- Parametrised multi-context general purpose register file for the pipeline. It is the successor to the single-context 2-read/1-write GPR.
- Holds NUM_THREAD independent register contexts and provides NUM_RD read ports plus one write port.
- Adds a per-register pending scoreboard: decode marks a destination pending, writeback clears it, and each read port reports busy so the pipeline can stall on RAW hazards.
- Sits between decode (reads, issue marks) and writeback (write port).

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width; the file has 2**ADDR_W registers per context
- NUM_THREAD, 4, number of register contexts (power of two, ≥1)
- NUM_RD, 2, number of read ports (≥1)
- THREAD_W, $clog2(NUM_THREAD) (minimum 1), thread-id width; derived, do not override

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- rd_tid  in  NUM_RD*THREAD_W  per-port thread id (port k occupies slice k)
- rd_addr  in  NUM_RD*ADDR_W  per-port register address
- rd_data  out  NUM_RD*DATA_W  per-port read data (combinational)
- rd_busy  out  NUM_RD  per-port busy flag: register pending, so data is not yet valid
- we_  in  1  write enable, active-low
- wr_tid  in  THREAD_W  write thread id
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- set_en_  in  1  scoreboard mark enable, active-low (decode issue)
- set_tid  in  THREAD_W  mark thread id
- set_addr  in  ADDR_W  destination register to mark pending
- pend_cnt  out  THREAD_W+ADDR_W+1  total number of pending bits across all contexts (registered)

Behaviour:
- Reset (reset low, asynchronous):
  - Every register in every context is cleared to 0.
  - All pending bits are cleared.
  - pend_cnt is 0; therefore every rd_busy is 0 and every rd_data is 0.
  - Reset mid-write or mid-mark discards that operation.
- Register 0 of every context:
  - Reads return 0 and rd_busy is 0.
  - Writes are ignored.
  - Marks are ignored.
- Read path: combinational, zero latency. rd_data[k] = context[rd_tid[k]][rd_addr[k]], subject to register 0 and the bypass rule in Optional Feature.
- Write:
  - On the rising edge with we_=0 and wr_addr≠0: context[wr_tid][wr_addr] <= wr_data, and the pending bit of that register is cleared.
- Mark:
  - On the rising edge with set_en_=0 and set_addr≠0: the pending bit of [set_tid][set_addr] is set.
  - Marking an already-pending register is legal; the bit stays set.
- Simultaneous write and mark on the same tid/addr: the data is written, and the pending bit ends up set (a new producer wins over the old one).
- rd_busy[k] = pending[rd_tid[k]][rd_addr[k]], evaluated on the pre-edge pending state and subject to the Optional Feature.
- pend_cnt:
  - Updated each edge as +1 for a mark of a non-pending register, and −1 for a write clearing a pending register.
  - Both in the same cycle on different registers: net 0.
  - Same register, already pending: net −0 (the bit stays set, count unchanged).
  - Never wraps; maximum value is NUM_THREAD*(2**ADDR_W−1).
- Contexts are fully independent: a write or mark in thread t never affects thread u≠t.
- Out-of-range tid (only possible when NUM_THREAD is not a power of two) is forbidden; the bench flags it as an assertion.

Optional Feature:
- Macro: GPR_BYPASS_EN.
- Defined, a read is bypassed when we_=0, wr_tid==rd_tid[k], wr_addr==rd_addr[k] and the address ≠0. In that case:
  - rd_data[k] = wr_data.
  - rd_busy[k] = 0.
- Undefined:
  - rd_data[k] returns the stored (old) value during the write cycle.
  - rd_busy[k] stays 1 until the cycle after the write edge.
  - This gives a one-cycle-longer stall but a shorter timing path.

Decomposition:
- Shared package gpr_pkg:
  - WORD_DATA_W=32, REG_ADDR_W=5, REG_NUM=32.
  - ENABLE_/DISABLE_ levels.
  - Packed tid/addr index helper type.
- Natural sub-module gpr_scoreboard:
  - Holds the pending bit array, mark/clear priority and the pend_cnt counter.
  - Provides NUM_RD busy lookups.
- gpr_mt instantiates gpr_scoreboard and holds the data array and read muxing.

Test Plan:
- Reset: pulse reset low mid-cycle after prior writes → every rd_data=0, rd_busy=0, pend_cnt=0 immediately, without waiting for a clock edge.
- Context isolation: write tid1 r5=0xDEADBEEF, then read tid1 r5 and tid2 r5 → 0xDEADBEEF and 0x00000000 respectively.
- r0: write 0x1234 and mark tid0 r0 → read returns 0, rd_busy=0, pend_cnt unchanged.
- Scoreboard round-trip: mark tid3 r7 → next cycle rd_busy=1, pend_cnt=1. Write tid3 r7=0x55 → with bypass, rd_busy=0 and rd_data=0x55 in the write cycle. Without bypass, both take effect one cycle later. pend_cnt returns to 0.
- Same-cycle write and mark on tid0 r9 while r9 is pending → data updated, bit still set, pend_cnt unchanged.
- Fill: mark all 31 registers in all 4 contexts → pend_cnt=124. Then clear all → 0, with no wrap.
